// File: rtl/nu_sequencer_if.sv
// nu_sequencer_if: host start/done, instruction fetch and datapath control bundle.
interface nu_sequencer_if #(
  parameter int PC_DEPTH  = 8,
  parameter int XY_DEPTH  = 5,
  parameter int W_DEPTH   = 5,
  parameter int INST_SIZE = 32,
  parameter int SEL_SIZE  = 2
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 inst_rd;
  logic [PC_DEPTH-1:0]  inst_addr;
  logic [INST_SIZE-1:0] inst_data;
  logic                 xy_rd;
  logic [XY_DEPTH-1:0]  xy_addr;
  logic                 w_rd;
  logic [W_DEPTH-1:0]   w_addr;
  logic                 nu_acc_en;
  logic                 nu_clear;
  logic                 act_en;
  logic [SEL_SIZE-1:0]  act_sel;
  logic                 xy_wr;
  logic [XY_DEPTH-1:0]  xy_wr_addr;
  modport master (
    input  start, inst_data,
    output busy, done, err, inst_rd, inst_addr, xy_rd, xy_addr, w_rd, w_addr,
           nu_acc_en, nu_clear, act_en, act_sel, xy_wr, xy_wr_addr
  );
  modport slave (
    output start, inst_data,
    input  busy, done, err, inst_rd, inst_addr, xy_rd, xy_addr, w_rd, w_addr,
           nu_acc_en, nu_clear, act_en, act_sel, xy_wr, xy_wr_addr
  );
endinterface

// File: rtl/nu_sequencer.sv
// nu_sequencer: instruction-driven controller for NU MAC bursts, activation sweeps and base updates.
// Define NU_SEQ_LOOP_EN to enable the single-level LOOP opcode (6); otherwise opcode 6 is illegal.
module nu_sequencer #(
  parameter int NU_COUNT  = 4,
  parameter int XY_DEPTH  = 5,
  parameter int W_DEPTH   = 5,
  parameter int PC_DEPTH  = 8,
  parameter int INST_SIZE = 32,
  parameter int REP_SIZE  = 28,
  parameter int SEL_SIZE  = 2
) (
  input logic clk,
  input logic rst_n,
  nu_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, MAC, ACT, CLR, DONE} state_t;
  state_t state_q, state_d;
  logic [PC_DEPTH-1:0] pc_q, pc_d;
  logic [XY_DEPTH-1:0] xb_q, xb_d, ob_q, ob_d;
  logic [W_DEPTH-1:0] wb_q, wb_d;
  logic [REP_SIZE-1:0] cnt_q, cnt_d, n_q, n_d;
  logic err_q, err_d, acc_q, acc_d;
  logic [3:0] op;
  logic [REP_SIZE-1:0] arg;
  assign op  = bus.inst_data[INST_SIZE-1 -: 4];
  assign arg = bus.inst_data[REP_SIZE-1:0];
`ifdef NU_SEQ_LOOP_EN
  logic [REP_SIZE-9:0] lc_q, lc_d;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    xb_d = xb_q;
    wb_d = wb_q;
    ob_d = ob_q;
    cnt_d = cnt_q;
    n_d = n_q;
    err_d = err_q;
    acc_d = (state_q == MAC);
`ifdef NU_SEQ_LOOP_EN
    lc_d = lc_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = FETCH;
        pc_d = '0;
        err_d = 1'b0;
`ifdef NU_SEQ_LOOP_EN
        lc_d = '0;
`endif
      end
      FETCH: begin
        pc_d = pc_q + PC_DEPTH'(1);
        state_d = DECODE;
      end
      DECODE: begin
        state_d = FETCH;
        cnt_d = '0;
        n_d = arg;
        case (op)
          4'h0: ;
          4'h1: xb_d = arg[XY_DEPTH-1:0];
          4'h2: wb_d = arg[W_DEPTH-1:0];
          4'h3: ob_d = arg[XY_DEPTH-1:0];
          4'h4: state_d = (arg != '0) ? MAC : FETCH;
          4'h5: state_d = ACT;
          4'hF: state_d = DONE;
`ifdef NU_SEQ_LOOP_EN
          // lc == 0 marks the loop counter idle, so a fresh LOOP reloads it
          4'h6: if (lc_q == '0) begin
            lc_d = arg[REP_SIZE-1:8];
            pc_d = (arg[REP_SIZE-1:8] != '0) ? arg[PC_DEPTH-1:0] : pc_q;
          end else begin
            lc_d = lc_q - 1'b1;
            pc_d = (lc_d != '0) ? arg[PC_DEPTH-1:0] : pc_q;
          end
`endif
          default: err_d = 1'b1;
        endcase
      end
      MAC: begin
        cnt_d = cnt_q + REP_SIZE'(1);
        if (cnt_q == n_q - REP_SIZE'(1)) begin
          state_d = FETCH;
          wb_d = wb_q + n_q[W_DEPTH-1:0];
        end
      end
      ACT: begin
        cnt_d = cnt_q + REP_SIZE'(1);
        state_d = (cnt_q == REP_SIZE'(NU_COUNT - 1)) ? CLR : ACT;
      end
      CLR: begin
        ob_d = ob_q + XY_DEPTH'(NU_COUNT);
        state_d = FETCH;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      xb_q <= '0;
      wb_q <= '0;
      ob_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      err_q <= 1'b0;
      acc_q <= 1'b0;
`ifdef NU_SEQ_LOOP_EN
      lc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      xb_q <= xb_d;
      wb_q <= wb_d;
      ob_q <= ob_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      err_q <= err_d;
      acc_q <= acc_d;
`ifdef NU_SEQ_LOOP_EN
      lc_q <= lc_d;
`endif
    end
  end
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = err_q;
  assign bus.inst_rd    = (state_q == FETCH);
  assign bus.inst_addr  = pc_q;
  assign bus.xy_rd      = (state_q == MAC);
  assign bus.w_rd       = (state_q == MAC);
  assign bus.xy_addr    = xb_q + cnt_q[XY_DEPTH-1:0];
  assign bus.w_addr     = wb_q + cnt_q[W_DEPTH-1:0];
  assign bus.nu_acc_en  = acc_q;
  assign bus.nu_clear   = (state_q == CLR);
  assign bus.act_en     = (state_q == ACT);
  assign bus.act_sel    = cnt_q[SEL_SIZE-1:0];
  assign bus.xy_wr      = (state_q == ACT);
  assign bus.xy_wr_addr = ob_q + cnt_q[XY_DEPTH-1:0];
endmodule

// File: tb/tb_nu_sequencer.sv
// tb_nu_sequencer: directed programs with hand-computed addresses, pulse counts and cycle timing.
module tb_nu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  nu_sequencer_if bus ();
  nu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] imem [256];
  always @(posedge clk) if (bus.inst_rd) bus.inst_data <= imem[bus.inst_addr];
  int gcyc = 0, acc_n = 0, lag_bad = 0, clr_n = 0, clr_cyc = 0;
  logic prev_rd = 1'b0;
  logic [4:0] xq[$], wq[$], waq[$];
  logic [1:0] selq[$];
  int actc[$];
  always @(negedge clk) begin
    gcyc++;
    if (bus.xy_rd) begin
      xq.push_back(bus.xy_addr);
      wq.push_back(bus.w_addr);
    end
    if (bus.nu_acc_en) acc_n++;
    if (bus.nu_acc_en !== prev_rd) lag_bad++;
    prev_rd = bus.xy_rd;
    if (bus.act_en) begin
      selq.push_back(bus.act_sel);
      waq.push_back(bus.xy_wr_addr);
      actc.push_back(gcyc);
    end
    if (bus.nu_clear) begin
      clr_n++;
      clr_cyc = gcyc;
    end
  end
  function automatic logic [34:0] outs();
    return {bus.busy, bus.done, bus.err, bus.inst_rd, bus.inst_addr, bus.xy_rd, bus.xy_addr,
            bus.w_rd, bus.w_addr, bus.nu_acc_en, bus.nu_clear, bus.act_en, bus.act_sel,
            bus.xy_wr, bus.xy_wr_addr};
  endfunction
  task automatic clr_mon();
    xq.delete(); wq.delete(); waq.delete(); selq.delete(); actc.delete();
    acc_n = 0; lag_bad = 0; clr_n = 0;
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d, input logic [31:0] e);
    for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
    imem[0] = a; imem[1] = b; imem[2] = c; imem[3] = d; imem[4] = e;
  endtask
  task automatic run_prog(output int n);
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      @(negedge clk); #1 n++;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1 tests++;
    if (outs() !== '0) begin fails++; $display("FAIL reset_outs: got %h want 0", outs()); end
    rst_n = 1'b1;
    @(negedge clk); #1 tests++;
    if (outs() !== '0) begin fails++; $display("FAIL idle_outs: got %h want 0", outs()); end
  endtask
  task automatic test_mac();
    int n;
    load(32'h1000_0003, 32'h2000_001E, 32'h4000_0004, 32'hF000_0000, 32'hF000_0000);
    clr_mon();
    run_prog(n);
    tests++;
    if (n != 12) begin fails++; $display("FAIL mac_done_cycle: got %0d want 12", n); end
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL mac_busy_at_done: got %b want 1", bus.busy); end
    @(negedge clk); #1 tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin fails++; $display("FAIL mac_busy_after: got %b want 00", {bus.busy, bus.done}); end
    tests++;
    if (xq.size() != 4) begin fails++; $display("FAIL mac_reads: got %0d want 4", xq.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests++;
      if (xq[i] !== 5'(3 + i)) begin fails++; $display("FAIL mac_xy_addr%0d: got %0d want %0d", i, xq[i], 3 + i); end
      tests++;
      if (wq[i] !== 5'(30 + i)) begin fails++; $display("FAIL mac_w_addr%0d: got %0d want %0d", i, wq[i], (30 + i) % 32); end
    end
    tests++;
    if (acc_n != 4) begin fails++; $display("FAIL mac_acc_pulses: got %0d want 4", acc_n); end
    tests++;
    if (lag_bad != 0) begin fails++; $display("FAIL mac_acc_lag: got %0d want 0", lag_bad); end
  endtask
  task automatic test_act();
    int n;
    load(32'h3000_0008, 32'h5000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000);
    clr_mon();
    run_prog(n);
    @(negedge clk); #1 tests++;
    if (n != 11) begin fails++; $display("FAIL act_done_cycle: got %0d want 11", n); end
    tests++;
    if (selq.size() != 4) begin fails++; $display("FAIL act_cycles: got %0d want 4", selq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (selq[i] !== 2'(i)) begin fails++; $display("FAIL act_sel%0d: got %0d want %0d", i, selq[i], i); end
        tests++;
        if (waq[i] !== 5'(8 + i)) begin fails++; $display("FAIL act_wr_addr%0d: got %0d want %0d", i, waq[i], 8 + i); end
      end
      tests++;
      if (actc[3] - actc[0] != 3) begin fails++; $display("FAIL act_consecutive: got %0d want 3", actc[3] - actc[0]); end
      tests++;
      if (clr_cyc != actc[3] + 1) begin fails++; $display("FAIL clr_timing: got %0d want %0d", clr_cyc, actc[3] + 1); end
    end
    tests++;
    if (clr_n != 1) begin fails++; $display("FAIL clr_pulses: got %0d want 1", clr_n); end
    tests++;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL act_err: got %b want 0", bus.err); end
  endtask
  task automatic test_err();
    int n;
    load(32'h4000_0000, 32'h9000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000);
    clr_mon();
    run_prog(n);
    tests++;
    if (n != 6) begin fails++; $display("FAIL err_done_cycle: got %0d want 6", n); end
    repeat (3) @(negedge clk);
    #1 tests++;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    tests++;
    if (xq.size() != 0 || acc_n != 0) begin fails++; $display("FAIL mac0_strobes: got %0d/%0d want 0/0", xq.size(), acc_n); end
    load(32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000);
    run_prog(n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL halt_done_cycle: got %0d want 2", n); end
    tests++;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", bus.err); end
  endtask
  task automatic test_mid_reset();
    int n;
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    load(32'h4000_000A, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000);
    clr_mon();
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    tests++;
    if ({bus.busy, bus.xy_rd, bus.xy_addr} !== {2'b11, 5'd2}) begin
      fails++; $display("FAIL mid_start_ignored: got %b/%b/%0d want 1/1/2", bus.busy, bus.xy_rd, bus.xy_addr);
    end
    rst_n = 1'b0;
    #1 tests++;
    if (outs() !== '0) begin fails++; $display("FAIL midreset_outs: got %h want 0", outs()); end
    repeat (3) @(negedge clk);
    #1 tests++;
    if (acc_n != 2) begin fails++; $display("FAIL midreset_acc: got %0d want 2", acc_n); end
    tests++;
    if (xq.size() != 3) begin fails++; $display("FAIL midreset_reads: got %0d want 3", xq.size()); end
    rst_n = 1'b1;
    clr_mon();
    run_prog(n);
    @(negedge clk); #1 tests++;
    if (n != 14) begin fails++; $display("FAIL restart_done_cycle: got %0d want 14", n); end
    tests++;
    if (xq.size() != 10 || acc_n != 10) begin fails++; $display("FAIL restart_burst: got %0d/%0d want 10/10", xq.size(), acc_n); end
    else begin
      tests++;
      if (xq[9] !== 5'd9) begin fails++; $display("FAIL restart_last_addr: got %0d want 9", xq[9]); end
    end
  endtask
  task automatic test_back_to_back();
    int n;
    load(32'h2000_0000, 32'h1000_0000, 32'h4000_0005, 32'h4000_0005, 32'hF000_0000);
    clr_mon();
    run_prog(n);
    @(negedge clk); #1 tests++;
    if (n != 20) begin fails++; $display("FAIL b2b_done_cycle: got %0d want 20", n); end
    tests++;
    if (wq.size() != 10) begin fails++; $display("FAIL b2b_reads: got %0d want 10", wq.size()); end
    else for (int i = 0; i < 10; i++) begin
      tests++;
      if (wq[i] !== 5'(i) || xq[i] !== 5'(i % 5)) begin
        fails++; $display("FAIL b2b_addr%0d: got w=%0d x=%0d want w=%0d x=%0d", i, wq[i], xq[i], i, i % 5);
      end
    end
    tests++;
    if (acc_n != 10) begin fails++; $display("FAIL b2b_acc_pulses: got %0d want 10", acc_n); end
    tests++;
    if (lag_bad != 0) begin fails++; $display("FAIL b2b_acc_lag: got %0d want 0", lag_bad); end
  endtask
  task automatic test_loop();
    int n;
    load(32'h4000_0001, 32'h6000_0200, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000);
    clr_mon();
    run_prog(n);
    @(negedge clk); #1;
`ifdef NU_SEQ_LOOP_EN
    tests++;
    if (n != 17) begin fails++; $display("FAIL loop_done_cycle: got %0d want 17", n); end
    tests++;
    if (xq.size() != 3 || acc_n != 3) begin fails++; $display("FAIL loop_macs: got %0d/%0d want 3/3", xq.size(), acc_n); end
    tests++;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL loop_err: got %b want 0", bus.err); end
`else
    tests++;
    if (n != 7) begin fails++; $display("FAIL loop_done_cycle: got %0d want 7", n); end
    tests++;
    if (xq.size() != 1 || acc_n != 1) begin fails++; $display("FAIL loop_macs: got %0d/%0d want 1/1", xq.size(), acc_n); end
    tests++;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL loop_err: got %b want 1", bus.err); end
`endif
  endtask
  initial begin
    bus.start = 1'b0;
    test_reset();
    test_mac();
    test_act();
    test_err();
    test_mid_reset();
    test_back_to_back();
    test_loop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
